// File: rtl/cpu_pkg.sv
// Shared types for the SAP CPU control path: opcodes, microstep type and the
// control-strobe bundle produced by the sequencer.
package cpu_pkg;

    localparam int unsigned STEPS_DEFAULT = 5;
    localparam int unsigned OPW_DEFAULT   = 4;
    localparam int unsigned STEP_W        = $clog2(STEPS_DEFAULT);

    typedef logic [STEP_W-1:0] step_t;

    localparam step_t STEP_T0 = step_t'(0);
    localparam step_t STEP_T1 = step_t'(1);
    localparam step_t STEP_T2 = step_t'(2);
    localparam step_t STEP_T3 = step_t'(3);
    localparam step_t STEP_T4 = step_t'(4);

    typedef enum logic [OPW_DEFAULT-1:0] {
        NOP = 4'b0000,
        LDA = 4'b0001,
        ADD = 4'b0010,
        SUB = 4'b0011,
        STA = 4'b0100,
        LDI = 4'b0101,
        JMP = 4'b0110,
        JC  = 4'b0111,
        JZ  = 4'b1000,
        OUT = 4'b1110,
        HLT = 4'b1111
    } opcode_t;

    typedef struct packed {
        logic halt;
        logic addressWEN;
        logic ramWEN;
        logic ramREN;
        logic iWEN;
        logic iREN;
        logic aWEN;
        logic aREN;
        logic aluREN;
        logic sub;
        logic bWEN;
        logic outputWEN;
        logic pcEN;
        logic pcREN;
        logic jump;
        logic flagWEN;
    } ctrl_t;

endpackage

// File: rtl/controller_if.sv
// Sequencer <-> datapath bundle: opcode/flags in, microstep and control strobes out.
interface controller_if;
    import cpu_pkg::*;

    logic [OPW_DEFAULT-1:0] opcode;
    logic                   zero_flag;
    logic                   carry_flag;
    step_t                  step;

    logic halt;
    logic addressWEN;
    logic ramWEN;
    logic ramREN;
    logic iWEN;
    logic iREN;
    logic aWEN;
    logic aREN;
    logic aluREN;
    logic sub;
    logic bWEN;
    logic outputWEN;
    logic pcEN;
    logic pcREN;
    logic jump;
    logic flagWEN;

    modport master (
        input  opcode, zero_flag, carry_flag,
        output step, halt, addressWEN, ramWEN, ramREN, iWEN, iREN, aWEN, aREN,
               aluREN, sub, bWEN, outputWEN, pcEN, pcREN, jump, flagWEN
    );

    modport slave (
        output opcode, zero_flag, carry_flag,
        input  step, halt, addressWEN, ramWEN, ramREN, iWEN, iREN, aWEN, aREN,
               aluREN, sub, bWEN, outputWEN, pcEN, pcREN, jump, flagWEN
    );

endinterface

// File: rtl/control_rom.sv
// Combinational microcode: (opcode, step, flags) -> control strobes, plus a flag
// marking the last non-empty step of the current instruction.
module control_rom
    import cpu_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEFAULT
) (
    input  logic [OPW-1:0] opcode,
    input  step_t          step,
    input  logic           zero,
    input  logic           carry,
    output ctrl_t          ctrl,
    output logic           lastStep
);

    opcode_t op;

    assign op = opcode_t'(opcode);

    always_comb begin
        ctrl     = '0;
        lastStep = 1'b0;

        // Fetch is shared by every opcode, including undefined ones.
        if (step == STEP_T0) begin
            ctrl.pcREN      = 1'b1;
            ctrl.addressWEN = 1'b1;
        end else if (step == STEP_T1) begin
            ctrl.ramREN = 1'b1;
            ctrl.iWEN   = 1'b1;
            ctrl.pcEN   = 1'b1;
        end

        case (op)
            LDA: begin
                if (step == STEP_T2) begin
                    ctrl.iREN       = 1'b1;
                    ctrl.addressWEN = 1'b1;
                end
                if (step == STEP_T3) begin
                    ctrl.ramREN = 1'b1;
                    ctrl.aWEN   = 1'b1;
                end
                lastStep = (step == STEP_T3);
            end
            ADD, SUB: begin
                if (step == STEP_T2) begin
                    ctrl.iREN       = 1'b1;
                    ctrl.addressWEN = 1'b1;
                end
                if (step == STEP_T3) begin
                    ctrl.ramREN = 1'b1;
                    ctrl.bWEN   = 1'b1;
                end
                if (step == STEP_T4) begin
                    ctrl.aluREN  = 1'b1;
                    ctrl.aWEN    = 1'b1;
                    ctrl.flagWEN = 1'b1;
                    ctrl.sub     = (op == SUB);
                end
                lastStep = (step == STEP_T4);
            end
            STA: begin
                if (step == STEP_T2) begin
                    ctrl.iREN       = 1'b1;
                    ctrl.addressWEN = 1'b1;
                end
                if (step == STEP_T3) begin
                    ctrl.aREN   = 1'b1;
                    ctrl.ramWEN = 1'b1;
                end
                lastStep = (step == STEP_T3);
            end
            LDI: begin
                if (step == STEP_T2) begin
                    ctrl.iREN = 1'b1;
                    ctrl.aWEN = 1'b1;
                end
                lastStep = (step == STEP_T2);
            end
            JMP: begin
                if (step == STEP_T2) begin
                    ctrl.iREN = 1'b1;
                    ctrl.jump = 1'b1;
                end
                lastStep = (step == STEP_T2);
            end
            JC: begin
                if (step == STEP_T2) begin
                    ctrl.iREN = 1'b1;
                    ctrl.jump = carry;
                end
                lastStep = (step == STEP_T2);
            end
            JZ: begin
                if (step == STEP_T2) begin
                    ctrl.iREN = 1'b1;
                    ctrl.jump = zero;
                end
                lastStep = (step == STEP_T2);
            end
            OUT: begin
                if (step == STEP_T2) begin
                    ctrl.aREN      = 1'b1;
                    ctrl.outputWEN = 1'b1;
                end
                lastStep = (step == STEP_T2);
            end
            HLT: begin
                if (step == STEP_T2) begin
                    ctrl.halt = 1'b1;
                end
                lastStep = (step == STEP_T2);
            end
            default: begin
                lastStep = (step == STEP_T1);
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP CPU microcode sequencer: microstep counter, halt latch and strobe gating.
// Define EARLY_STEP_RESET_EN to end each instruction after its last non-empty step.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned STEPS = STEPS_DEFAULT,
    parameter int unsigned OPW   = OPW_DEFAULT
) (
    input  logic         CLK,
    input  logic         RST,
    controller_if.master bus
);

    localparam step_t LAST_STEP = step_t'(STEPS - 1);

    step_t  stepQ;
    step_t  stepNext;
    logic   halted;
    logic   haltNow;
    logic   lastStep;
    ctrl_t  romCtrl;
    ctrl_t  ctrl;

    control_rom #(
        .OPW (OPW)
    ) u_rom (
        .opcode   (bus.opcode),
        .step     (stepQ),
        .zero     (bus.zero_flag),
        .carry    (bus.carry_flag),
        .ctrl     (romCtrl),
        .lastStep (lastStep)
    );

    // The ROM raises halt only for HLT in T2, so it doubles as the latch trigger.
    assign haltNow = romCtrl.halt && !halted;

    always_comb begin
        stepNext = stepQ;
        // Freezing on the triggering edge keeps step at T2 once halted.
        if (!halted && !haltNow) begin
`ifdef EARLY_STEP_RESET_EN
            if (lastStep || (stepQ == LAST_STEP)) begin
                stepNext = '0;
            end else begin
                stepNext = stepQ + step_t'(1);
            end
`else
            if (stepQ == LAST_STEP) begin
                stepNext = '0;
            end else begin
                stepNext = stepQ + step_t'(1);
            end
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stepQ  <= '0;
            halted <= 1'b0;
        end else begin
            stepQ <= stepNext;
            if (haltNow) begin
                halted <= 1'b1;
            end
        end
    end

`ifndef EARLY_STEP_RESET_EN
    logic unusedLastStep;
    assign unusedLastStep = lastStep;
`endif

    always_comb begin
        ctrl = romCtrl;
        if (halted) begin
            ctrl      = '0;
            ctrl.halt = 1'b1;
        end
    end

    assign bus.step       = stepQ;
    assign bus.halt       = ctrl.halt;
    assign bus.addressWEN = ctrl.addressWEN;
    assign bus.ramWEN     = ctrl.ramWEN;
    assign bus.ramREN     = ctrl.ramREN;
    assign bus.iWEN       = ctrl.iWEN;
    assign bus.iREN       = ctrl.iREN;
    assign bus.aWEN       = ctrl.aWEN;
    assign bus.aREN       = ctrl.aREN;
    assign bus.aluREN     = ctrl.aluREN;
    assign bus.sub        = ctrl.sub;
    assign bus.bWEN       = ctrl.bWEN;
    assign bus.outputWEN  = ctrl.outputWEN;
    assign bus.pcEN       = ctrl.pcEN;
    assign bus.pcREN      = ctrl.pcREN;
    assign bus.jump       = ctrl.jump;
    assign bus.flagWEN    = ctrl.flagWEN;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-step strobe tables for each opcode,
// instruction periods, mid-cycle reset and halt behaviour.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam logic [15:0] M_HALT = 16'h8000;
    localparam logic [15:0] M_AW   = 16'h4000;
    localparam logic [15:0] M_RAMW = 16'h2000;
    localparam logic [15:0] M_RAMR = 16'h1000;
    localparam logic [15:0] M_IW   = 16'h0800;
    localparam logic [15:0] M_IR   = 16'h0400;
    localparam logic [15:0] M_AWE  = 16'h0200;
    localparam logic [15:0] M_AR   = 16'h0100;
    localparam logic [15:0] M_ALUR = 16'h0080;
    localparam logic [15:0] M_SUB  = 16'h0040;
    localparam logic [15:0] M_BW   = 16'h0020;
    localparam logic [15:0] M_OUTW = 16'h0010;
    localparam logic [15:0] M_PCEN = 16'h0008;
    localparam logic [15:0] M_PCR  = 16'h0004;
    localparam logic [15:0] M_JMP  = 16'h0002;
    localparam logic [15:0] M_FLW  = 16'h0001;

    localparam logic [15:0] F0 = M_PCR | M_AW;
    localparam logic [15:0] F1 = M_RAMR | M_IW | M_PCEN;

`ifdef EARLY_STEP_RESET_EN
    localparam int unsigned LEN_NOP = 2;
    localparam int unsigned LEN_T2  = 3;
    localparam int unsigned LEN_T3  = 4;
    localparam int unsigned LEN_T4  = 5;
`else
    localparam int unsigned LEN_NOP = 5;
    localparam int unsigned LEN_T2  = 5;
    localparam int unsigned LEN_T3  = 5;
    localparam int unsigned LEN_T4  = 5;
`endif

    logic        CLK;
    logic        RST;
    int unsigned checks;
    int unsigned errors;

    controller_if bus ();

    control_sequencer #(
        .STEPS (5),
        .OPW   (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] getCtrl();
        return {bus.halt, bus.addressWEN, bus.ramWEN, bus.ramREN, bus.iWEN, bus.iREN,
                bus.aWEN, bus.aREN, bus.aluREN, bus.sub, bus.bWEN, bus.outputWEN,
                bus.pcEN, bus.pcREN, bus.jump, bus.flagWEN};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            check("onehot0_ren",
                  32'($onehot0({bus.ramREN, bus.iREN, bus.aREN, bus.aluREN, bus.pcREN})),
                  32'd1);
        end
    end

    // Entered in the low phase of an instruction's T0; returns in the low phase of the next T0.
    task automatic runInstr(input string tag, input logic [3:0] opc, input logic z,
                            input logic c, input int unsigned len,
                            input logic [15:0] e2, input logic [15:0] e3,
                            input logic [15:0] e4);
        logic [15:0] exp;
        bus.opcode     = opc;
        bus.zero_flag  = z;
        bus.carry_flag = c;
        for (int s = 0; s < int'(len); s++) begin
            case (s)
                0:       exp = F0;
                1:       exp = F1;
                2:       exp = e2;
                3:       exp = e3;
                default: exp = e4;
            endcase
            #1;
            check($sformatf("%s.T%0d.step", tag, s), 32'(bus.step), 32'(s));
            check($sformatf("%s.T%0d.ctrl", tag, s), 32'(getCtrl()), 32'(exp));
            @(negedge CLK);
        end
        #1;
        check($sformatf("%s.period", tag), 32'(bus.step), 32'd0);
    endtask

    task automatic resetPulse(input string tag);
        RST = 1'b1;
        #1;
        check({tag, ".step"}, 32'(bus.step), 32'd0);
        check({tag, ".ctrl"}, 32'(getCtrl()), 32'(F0));
        check({tag, ".halt"}, 32'(bus.halt), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        RST            = 1'b1;
        bus.opcode     = 4'b0000;
        bus.zero_flag  = 1'b0;
        bus.carry_flag = 1'b0;

        #2;
        check("reset.step", 32'(bus.step), 32'd0);
        check("reset.ctrl", 32'(getCtrl()), 32'(F0));
        @(negedge CLK);
        RST = 1'b0;

        runInstr("LDA", 4'b0001, 1'b0, 1'b0, LEN_T3, M_IR | M_AW, M_RAMR | M_AWE, 16'h0000);
        runInstr("SUB", 4'b0011, 1'b0, 1'b0, LEN_T4, M_IR | M_AW, M_RAMR | M_BW,
                 M_ALUR | M_AWE | M_FLW | M_SUB);
        runInstr("ADD", 4'b0010, 1'b1, 1'b1, LEN_T4, M_IR | M_AW, M_RAMR | M_BW,
                 M_ALUR | M_AWE | M_FLW);
        runInstr("STA", 4'b0100, 1'b0, 1'b0, LEN_T3, M_IR | M_AW, M_AR | M_RAMW, 16'h0000);
        runInstr("LDI", 4'b0101, 1'b0, 1'b0, LEN_T2, M_IR | M_AWE, 16'h0000, 16'h0000);
        runInstr("JMP", 4'b0110, 1'b0, 1'b0, LEN_T2, M_IR | M_JMP, 16'h0000, 16'h0000);
        runInstr("JC_c0", 4'b0111, 1'b0, 1'b0, LEN_T2, M_IR, 16'h0000, 16'h0000);
        runInstr("JC_c1", 4'b0111, 1'b0, 1'b1, LEN_T2, M_IR | M_JMP, 16'h0000, 16'h0000);
        runInstr("JC_z1c0", 4'b0111, 1'b1, 1'b0, LEN_T2, M_IR, 16'h0000, 16'h0000);
        runInstr("JZ_z0", 4'b1000, 1'b0, 1'b1, LEN_T2, M_IR, 16'h0000, 16'h0000);
        runInstr("JZ_z1", 4'b1000, 1'b1, 1'b0, LEN_T2, M_IR | M_JMP, 16'h0000, 16'h0000);
        runInstr("OUT", 4'b1110, 1'b0, 1'b0, LEN_T2, M_AR | M_OUTW, 16'h0000, 16'h0000);
        runInstr("UNDEF_1010", 4'b1010, 1'b1, 1'b1, LEN_NOP, 16'h0000, 16'h0000, 16'h0000);

        runInstr("b2b_NOP", 4'b0000, 1'b0, 1'b0, LEN_NOP, 16'h0000, 16'h0000, 16'h0000);
        runInstr("b2b_LDI", 4'b0101, 1'b0, 1'b0, LEN_T2, M_IR | M_AWE, 16'h0000, 16'h0000);
        runInstr("b2b_LDA", 4'b0001, 1'b0, 1'b0, LEN_T3, M_IR | M_AW, M_RAMR | M_AWE, 16'h0000);
        runInstr("b2b_ADD", 4'b0010, 1'b0, 1'b0, LEN_T4, M_IR | M_AW, M_RAMR | M_BW,
                 M_ALUR | M_AWE | M_FLW);

        bus.opcode = 4'b0010;
        repeat (3) @(negedge CLK);
        #1;
        check("addT3.step", 32'(bus.step), 32'd3);
        check("addT3.ctrl", 32'(getCtrl()), 32'(M_RAMR | M_BW));
        #1;
        resetPulse("rstMidAdd");

        bus.opcode = 4'b1111;
        #1;
        check("HLT.T0.ctrl", 32'(getCtrl()), 32'(F0));
        @(negedge CLK);
        #1;
        check("HLT.T1.ctrl", 32'(getCtrl()), 32'(F1));
        @(negedge CLK);
        #1;
        check("HLT.T2.step", 32'(bus.step), 32'd2);
        check("HLT.T2.ctrl", 32'(getCtrl()), 32'(M_HALT));
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 5) begin
                bus.opcode     = 4'b0010;
                bus.zero_flag  = 1'b1;
                bus.carry_flag = 1'b1;
            end
            #1;
            check($sformatf("halted%0d.step", i), 32'(bus.step), 32'd2);
            check($sformatf("halted%0d.ctrl", i), 32'(getCtrl()), 32'(M_HALT));
        end
        #1;
        resetPulse("rstHalted");
        bus.opcode     = 4'b0000;
        bus.zero_flag  = 1'b0;
        bus.carry_flag = 1'b0;
        runInstr("postHalt_NOP", 4'b0000, 1'b0, 1'b0, LEN_NOP, 16'h0000, 16'h0000, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
